// File: rtl/conv_pkg.sv
// Shared sizes, FSM encoding and PE tag layout for the 2x2 convolution sequencer.
package conv_pkg;
  localparam int NUM_WIDTH  = 8;
  localparam int IN_ROWS    = 4;
  localparam int IN_COLS    = 4;
  localparam int PE_LATENCY = 4;
  localparam int ADDR_W     = 2;
  localparam int IDX_W      = 2;
  localparam int ROW_W      = IN_COLS * NUM_WIDTH;
  localparam int RES_W      = 2 * NUM_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_CAPTURE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } tag_t;
endpackage

// File: rtl/pe_tag_pipe.sv
// Tag shift register that mirrors the PE pipeline; advances only when the PE does.
module pe_tag_pipe
  import conv_pkg::*;
#(
  parameter int DEPTH = PE_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic adv,
  input  tag_t tag_in,
  output tag_t tag_tail,
  output logic upstream_valid
);

  tag_t tag_p [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
    end else if (adv) begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Anything still in flight ahead of the tail entry.
  always_comb begin
    upstream_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) upstream_valid = upstream_valid | tag_p[i].valid;
  end

  assign tag_tail = tag_p[DEPTH-1];

endmodule

// File: rtl/pe_conv_sequencer.sv
// Drives one 4-lane PE through a 2x2 stride-1 convolution, emitting results in raster order.
module pe_conv_sequencer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  weight_in,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ROW_W-1:0]  rd_data,
  output logic              pe_enable,
  output logic [ROW_W-1:0]  pe_data,
  output logic [ROW_W-1:0]  pe_weight,
  input  logic [RES_W-1:0]  pe_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [IDX_W-1:0]  res_row,
  output logic [IDX_W-1:0]  res_col
);

  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(IN_COLS - 2);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(IN_ROWS - 2);

  function automatic logic [NUM_WIDTH-1:0] elem(input logic [ROW_W-1:0] row,
                                                input logic [IDX_W-1:0] idx);
    return row[int'(idx)*NUM_WIDTH +: NUM_WIDTH];
  endfunction

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       r, c, c_nxt_idx;
  logic [ROW_W-1:0]       row_a, row_b, weight_q;
  logic                   stall, upstream_valid;
  tag_t                   tag_in, tag_tail;

  assign stall     = res_valid && !res_ready;
  assign pe_enable = (state != S_IDLE) && !stall;
  assign busy      = (state != S_IDLE);
  assign pe_weight = weight_q;
  assign c_nxt_idx = c + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = r;
    pe_data   = '0;
    tag_in    = '0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH0;
      S_FETCH0: begin
        rd_en     = 1'b1;
        state_nxt = S_FETCH1;
      end
      S_FETCH1: begin
        rd_en     = 1'b1;
        rd_addr   = r + 2'd1;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_ISSUE;
      S_ISSUE: begin
        pe_data = {elem(row_b, c_nxt_idx), elem(row_b, c),
                   elem(row_a, c_nxt_idx), elem(row_a, c)};
        tag_in  = '{valid: 1'b1, row: r, col: c};
        if (!stall && c == LAST_COL)
          state_nxt = (r == LAST_ROW) ? S_DRAIN : S_FETCH0;
      end
      // Leave once this edge empties the pipe: no stall, nothing behind the tail.
      S_DRAIN:   if (!stall && !upstream_valid) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r        <= '0;
      c        <= '0;
      row_a    <= '0;
      row_b    <= '0;
      weight_q <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      case (state)
        S_IDLE: if (start) begin
          weight_q <= weight_in;
          r        <= '0;
        end
        S_FETCH1:  row_a <= rd_data;
        S_CAPTURE: begin
          row_b <= rd_data;
          c     <= '0;
        end
        S_ISSUE: if (!stall) begin
          if (c == LAST_COL) begin
            if (r != LAST_ROW) r <= r + 2'd1;
          end else begin
            c <= c_nxt_idx;
          end
        end
        default: ;
      endcase
    end
  end

  pe_tag_pipe #(.DEPTH(PE_LATENCY)) u_tag_pipe (
    .clk            (clk),
    .reset          (reset),
    .adv            (pe_enable),
    .tag_in         (tag_in),
    .tag_tail       (tag_tail),
    .upstream_valid (upstream_valid)
  );

  assign res_valid = tag_tail.valid;
  assign res_row   = tag_tail.row;
  assign res_col   = tag_tail.col;
  assign res_data  = pe_result;

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Directed bench for pe_conv_sequencer with a scratchpad model and a frozen-on-stall PE model.
module tb_pe_conv_sequencer;
  import conv_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ROW_W-1:0]  weight_in = '0;
  logic              busy, done, rd_en, pe_enable, res_valid;
  logic              res_ready = 1'b1;
  logic [ADDR_W-1:0] rd_addr;
  logic [ROW_W-1:0]  rd_data;
  logic [ROW_W-1:0]  pe_data, pe_weight;
  logic [RES_W-1:0]  pe_result, res_data;
  logic [IDX_W-1:0]  res_row, res_col;

  pe_conv_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .weight_in (weight_in),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pe_enable (pe_enable),
    .pe_data   (pe_data),
    .pe_weight (pe_weight),
    .pe_result (pe_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_row   (res_row),
    .res_col   (res_col)
  );

  always #5 clk = ~clk;

  logic [ROW_W-1:0] mem [IN_ROWS];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [RES_W-1:0] dot(input logic [ROW_W-1:0] d, input logic [ROW_W-1:0] w);
    logic [RES_W-1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + RES_W'(d[8*k +: 8]) * RES_W'(w[8*k +: 8]);
    return s;
  endfunction

  logic [RES_W-1:0] pe_p [PE_LATENCY];
  always @(posedge clk) begin
    if (pe_enable) begin
      pe_p[0] <= dot(pe_data, pe_weight);
      for (int i = 1; i < PE_LATENCY; i++) pe_p[i] <= pe_p[i-1];
    end
  end
  assign pe_result = pe_p[PE_LATENCY-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  localparam int MAXC = 60;
  int               res_cnt, done_cnt, done_cyc;
  int               res_k [16];
  logic [RES_W-1:0] res_d [16];
  logic [1:0]       res_r [16], res_c [16];
  logic             log_v [MAXC], log_en [MAXC], log_busy [MAXC];
  logic [RES_W-1:0] log_d [MAXC];
  logic [1:0]       log_r [MAXC], log_c [MAXC];
  logic             snap_busy, snap_done, snap_rd_en, snap_en, snap_valid;
  logic [1:0]       snap_row, snap_col;
  logic [ROW_W-1:0] snap_data, snap_weight;

  // Cycle 0 is the cycle in which start is high and sampled at its closing edge.
  task automatic run_job(input logic [ROW_W-1:0] w, input int lo_s, input int lo_e,
                         input int restart_cyc, input int abort_cyc);
    res_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int k = 0; k < MAXC; k++) begin
      log_v[k] = 1'b0; log_en[k] = 1'b0; log_busy[k] = 1'b0;
      log_d[k] = '0; log_r[k] = '0; log_c[k] = '0;
    end
    @(posedge clk); #1;
    start = 1'b1; weight_in = w; res_ready = !(lo_s <= 0 && 0 <= lo_e);
    for (int k = 0; k < MAXC; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start     = (k == restart_cyc);
        weight_in = (k == restart_cyc) ? 32'h02020202 : w;
        res_ready = !(lo_s <= k && k <= lo_e);
        if (k == abort_cyc) reset = 1'b1;
      end
      @(negedge clk);
      log_v[k] = res_valid; log_en[k] = pe_enable; log_busy[k] = busy;
      log_d[k] = res_data;  log_r[k] = res_row;    log_c[k] = res_col;
      if (res_valid && res_ready && res_cnt < 16) begin
        res_k[res_cnt] = k; res_d[res_cnt] = res_data;
        res_r[res_cnt] = res_row; res_c[res_cnt] = res_col;
        res_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == abort_cyc) begin
        snap_busy = busy; snap_done = done; snap_rd_en = rd_en; snap_en = pe_enable;
        snap_valid = res_valid; snap_row = res_row; snap_col = res_col;
        snap_data = pe_data; snap_weight = pe_weight;
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    start = 1'b0; res_ready = 1'b1;
  endtask

  task automatic load_ramp();
    mem[0] = 32'h03020100; mem[1] = 32'h07060504;
    mem[2] = 32'h0B0A0908; mem[3] = 32'h0F0E0D0C;
  endtask

  task automatic check_ramp(input string t);
    int exp_v [9] = '{10, 14, 18, 26, 30, 34, 42, 46, 50};
    check({t, "_count"}, res_cnt, 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s_val%0d", t, i), res_d[i], exp_v[i]);
      check($sformatf("%s_row%0d", t, i), res_r[i], i / 3);
      check($sformatf("%s_col%0d", t, i), res_c[i], i % 3);
    end
    check({t, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < PE_LATENCY; i++) pe_p[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_pe_enable", pe_enable, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_pe_weight", pe_weight, 0);

    // Test 1: all-ones rows and kernel
    for (int i = 0; i < IN_ROWS; i++) mem[i] = 32'h01010101;
    run_job(32'h01010101, -1, -1, -1, -1);
    check("t1_count", res_cnt, 9);
    for (int i = 0; i < 9; i++) check($sformatf("t1_val%0d", i), res_d[i], 4);
    check("t1_en_c0", log_en[0], 0);
    check("t1_en_c1", log_en[1], 1);
    check("t1_first_cyc", res_k[0], 8);
    check("t1_res2_cyc", res_k[2], 10);
    check("t1_bubble_c11", log_v[11], 0);
    check("t1_res3_cyc", res_k[3], 14);
    check("t1_last_cyc", res_k[8], 22);
    check("t1_done_cyc", done_cyc, 23);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_c22", log_busy[22], 1);
    check("t1_busy_c23", log_busy[23], 0);

    // Test 2: ramp input, unit kernel
    load_ramp();
    run_job(32'h01010101, -1, -1, -1, -1);
    check_ramp("t2");

    // Test 3: full-scale values
    for (int i = 0; i < IN_ROWS; i++) mem[i] = 32'hFFFFFFFF;
    run_job(32'hFFFFFFFF, -1, -1, -1, -1);
    check("t3_count", res_cnt, 9);
    for (int i = 0; i < 9; i++) check($sformatf("t3_val%0d", i), res_d[i], 260100);

    // Test 4: backpressure in cycles 8-11
    load_ramp();
    run_job(32'h01010101, 8, 11, -1, -1);
    for (int k = 8; k <= 11; k++) begin
      check($sformatf("t4_valid_c%0d", k), log_v[k], 1);
      check($sformatf("t4_en_c%0d", k), log_en[k], 0);
      check($sformatf("t4_data_c%0d", k), log_d[k], 10);
      check($sformatf("t4_rc_c%0d", k), {log_r[k], log_c[k]}, 0);
    end
    check_ramp("t4");
    check("t4_first_cyc", res_k[0], 12);
    check("t4_res3_cyc", res_k[3], 16);
    check("t4_done_cyc", done_cyc, 25);

    // Test 5: reset mid-job, then a clean job
    run_job(32'h01010101, -1, -1, -1, 12);
    check("t5_busy", snap_busy, 0);
    check("t5_done", snap_done, 0);
    check("t5_rd_en", snap_rd_en, 0);
    check("t5_pe_enable", snap_en, 0);
    check("t5_res_valid", snap_valid, 0);
    check("t5_res_rc", {snap_row, snap_col}, 0);
    check("t5_pe_data", snap_data, 0);
    check("t5_pe_weight", snap_weight, 0);
    run_job(32'h01010101, -1, -1, -1, -1);
    check_ramp("t5");

    // Test 6: second start with another kernel is ignored
    run_job(32'h01010101, -1, -1, 5, -1);
    check_ramp("t6");
    check("t6_done_cyc", done_cyc, 23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
